// File: rtl/store_commit_unit.sv
// store_commit_unit: store buffer between the ROB head and the data-memory
// write port. Committed stores are lane-encoded on entry, queued in a small
// FIFO and drained one write at a time by an IDLE/WRITE/WAIT FSM.
// Optional build macro: STORE_COMMIT_FWD_EN adds store-to-load forwarding of
// fully-written buffered words.
module store_commit_unit #(
  parameter int SB_DEPTH    = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rob_store_valid_in,
  input  logic [31:0] rob_addr_in,
  input  logic [31:0] rob_data_in,
  input  logic [1:0]  rob_size_in,
  output logic        store_read_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_wstrb_out,
  output logic        sb_empty_out,
  output logic        misalign_err_out,
  input  logic [31:0] ld_addr_in,
  output logic        ld_hit_out,
  output logic [31:0] ld_data_out
);

  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // One buffered store, already in memory-port format.
  typedef struct packed {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  strb;
  } entry_t;

  entry_t           sb_mem [SB_DEPTH];
  entry_t           new_entry;
  entry_t           issue_entry;
  logic             new_legal;
  logic             enq;
  logic             pop;
  logic             issue_go;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [3:0]       wait_cnt;
  state_t           state;

  // Encode the incoming store into word address, byte strobes and lane-shifted data.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    new_entry.word = rob_addr_in[31:2];
    new_entry.data = '0;
    new_entry.strb = '0;
    new_legal      = 1'b0;
    case (rob_size_in)
      2'd0: begin
        new_entry.strb = 4'b0001 << rob_addr_in[1:0];
        new_entry.data = {24'b0, rob_data_in[7:0]} << {rob_addr_in[1:0], 3'b000};
        new_legal      = 1'b1;
      end
      2'd1: begin
        new_entry.strb = 4'b0011 << rob_addr_in[1:0];
        new_entry.data = {16'b0, rob_data_in[15:0]} << {rob_addr_in[1:0], 3'b000};
        new_legal      = ~rob_addr_in[0];
      end
      2'd2: begin
        new_entry.strb = 4'hF;
        new_entry.data = rob_data_in;
        new_legal      = (rob_addr_in[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  // Handshake: capacity is judged on the registered occupancy, so a drain
  // finishing this cycle never frees a slot for the same edge.
  assign store_read_out = rob_store_valid_in && (count < CNT_W'(SB_DEPTH)) && !rst_in;
  assign enq            = store_read_out && new_legal;
  assign pop            = (state == ST_WRITE);
  assign sb_empty_out   = (count == '0) && (state == ST_IDLE);

  // Next write source: the oldest buffered entry, or the arriving store when
  // the buffer is empty so an idle drain issues without an extra cycle.
  always_comb begin
    issue_entry = (count != '0) ? sb_mem[head] : new_entry;
    issue_go    = (count != '0) || enq;
  end

  // Store-buffer storage, written at the tail on enqueue.
  // NOTE: the storage array is not reset; occupancy qualifies every read, so stale contents are never visible.
  always_ff @(posedge clk_in) begin
    if (enq) sb_mem[tail] <= new_entry;
  end

  // Pointers, occupancy, sticky error and the drain FSM with registered port outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= ST_IDLE;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      wait_cnt         <= '0;
      misalign_err_out <= 1'b0;
      mem_we_out       <= 1'b0;
      mem_addr_out     <= '0;
      mem_wdata_out    <= '0;
      mem_wstrb_out    <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(pop);
      if (store_read_out && !new_legal) misalign_err_out <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (issue_go) begin
            mem_we_out    <= 1'b1;
            mem_addr_out  <= {issue_entry.word, 2'b00};
            mem_wdata_out <= issue_entry.data;
            mem_wstrb_out <= issue_entry.strb;
            state         <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          mem_we_out    <= 1'b0;
          mem_addr_out  <= '0;
          mem_wdata_out <= '0;
          mem_wstrb_out <= '0;
          if (MEM_LATENCY > 1) begin
            wait_cnt <= 4'(MEM_LATENCY - 1);
            state    <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt <= 4'd1) state <= ST_IDLE;
          else wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STORE_COMMIT_FWD_EN
  entry_t fwd_entry;
  logic   fwd_found;
  logic   unused_ld_lane;

  assign unused_ld_lane = ^ld_addr_in[1:0];

  // Forwarding compare: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_found = 1'b0;
    fwd_entry = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if ((CNT_W'(k) < count) &&
          (sb_mem[head + PTR_W'(k)].word == ld_addr_in[31:2])) begin
        fwd_found = 1'b1;
        fwd_entry = sb_mem[head + PTR_W'(k)];
      end
    end
    ld_hit_out  = fwd_found && (fwd_entry.strb == 4'hF);
    ld_data_out = ld_hit_out ? fwd_entry.data : '0;
  end
`else
  logic unused_ld;

  assign unused_ld   = ^ld_addr_in;
  assign ld_hit_out  = 1'b0;
  assign ld_data_out = '0;
`endif

endmodule

// File: tb/tb_store_commit_unit.sv
// tb_store_commit_unit: directed plus randomized stimulus for store_commit_unit,
// checked every cycle against a queue-based model of the store buffer in which
// each accepted store carries the cycle its memory write is due.
module tb_store_commit_unit;

  localparam int SB_DEPTH    = 4;
  localparam int MEM_LATENCY = 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rob_store_valid_in;
  logic [31:0] rob_addr_in;
  logic [31:0] rob_data_in;
  logic [1:0]  rob_size_in;
  logic        store_read_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_wstrb_out;
  logic        sb_empty_out;
  logic        misalign_err_out;
  logic [31:0] ld_addr_in;
  logic        ld_hit_out;
  logic [31:0] ld_data_out;

  store_commit_unit #(.SB_DEPTH(SB_DEPTH), .MEM_LATENCY(MEM_LATENCY)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rob_store_valid_in (rob_store_valid_in),
    .rob_addr_in        (rob_addr_in),
    .rob_data_in        (rob_data_in),
    .rob_size_in        (rob_size_in),
    .store_read_out     (store_read_out),
    .mem_we_out         (mem_we_out),
    .mem_addr_out       (mem_addr_out),
    .mem_wdata_out      (mem_wdata_out),
    .mem_wstrb_out      (mem_wstrb_out),
    .sb_empty_out       (sb_empty_out),
    .misalign_err_out   (misalign_err_out),
    .ld_addr_in         (ld_addr_in),
    .ld_hit_out         (ld_hit_out),
    .ld_data_out        (ld_data_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a pending store and the edge on which its write appears.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          wr_edge;
  } pend_t;

  pend_t q[$];
  int    cyc         = 0;
  int    last_wr     = -100;
  int    last_obs_we = -100;
  bit    exp_err     = 1'b0;
  bit    last_take   = 1'b0;
  int    checks      = 0;
  int    failures    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Store encoding from byte count and lane arithmetic.
  function automatic void ref_encode(input logic [31:0] a, input logic [31:0] d,
                                     input logic [1:0] s, output bit legal,
                                     output logic [3:0] strb, output logic [31:0] wd);
    int n = 1 << s;
    int lane = int'(a % 4);
    longint unsigned mask;
    legal = (s != 2'd3) && ((a % n) == 0);
    mask  = (64'd1 << (8 * n)) - 64'd1;
    strb  = 4'(((1 << n) - 1) << lane);
    wd    = 32'(((64'(d)) & mask) << (8 * lane));
  endfunction

  // Compare all registered/derived outputs for the current cycle.
  task automatic check_outputs();
    bit          exp_we;
    bit          found;
    pend_t       m;
    logic        exp_hit;
    logic [31:0] exp_ld;
    exp_we = (q.size() > 0) && (q[0].wr_edge == cyc);
    check("mem_we", mem_we_out, exp_we);
    check("mem_addr", mem_addr_out, exp_we ? q[0].addr : 32'h0);
    check("mem_wdata", mem_wdata_out, exp_we ? q[0].data : 32'h0);
    check("mem_wstrb", mem_wstrb_out, exp_we ? q[0].strb : 4'h0);
    check("sb_empty", sb_empty_out, (q.size() == 0) && (cyc >= last_wr + MEM_LATENCY));
    check("misalign_err", misalign_err_out, exp_err);
    if (mem_we_out === 1'b1) begin
      check("we_spacing", (cyc - last_obs_we) >= MEM_LATENCY, 1'b1);
      last_obs_we = cyc;
    end
    found = 1'b0;
    m     = '{32'h0, 32'h0, 4'h0, 0};
    for (int i = q.size() - 1; i >= 0 && !found; i--) begin
      if (q[i].addr[31:2] == ld_addr_in[31:2]) begin
        found = 1'b1;
        m     = q[i];
      end
    end
`ifdef STORE_COMMIT_FWD_EN
    exp_hit = found && (m.strb == 4'hF);
    exp_ld  = exp_hit ? m.data : 32'h0;
`else
    exp_hit = 1'b0;
    exp_ld  = 32'h0;
`endif
    check("ld_hit", ld_hit_out, exp_hit);
    check("ld_data", ld_data_out, exp_ld);
  endtask

  // One clock: drive, check the handshake, advance model across the edge, check outputs.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic r);
    bit          legal;
    logic [3:0]  strb;
    logic [31:0] wd;
    int          wr;
    rob_store_valid_in = v;
    rob_addr_in        = a;
    rob_data_in        = d;
    rob_size_in        = s;
    rst_in             = r;
    #1;
    last_take = v && !r && (q.size() < SB_DEPTH);
    check("store_read", store_read_out, last_take);
    @(posedge clk_in);
    cyc++;
    if (r) begin
      q.delete();
      last_wr     = -100;
      last_obs_we = -100;
      exp_err     = 1'b0;
    end else begin
      while (q.size() > 0 && q[0].wr_edge + 1 <= cyc) void'(q.pop_front());
      if (last_take) begin
        ref_encode(a, d, s, legal, strb, wd);
        if (!legal) exp_err = 1'b1;
        else begin
          wr = (cyc > last_wr + MEM_LATENCY + 1) ? cyc : last_wr + MEM_LATENCY + 1;
          q.push_back('{a & 32'hFFFF_FFFC, wd, strb, wr});
          last_wr = wr;
        end
      end
    end
    @(negedge clk_in);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  // Present one store and hold it until accepted, within a cycle budget.
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int budget = 40;
    do begin
      step(1'b1, a, d, s, 1'b0);
      budget--;
    end while (!last_take && budget > 0);
    check("push_budget", last_take, 1'b1);
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra;
    ld_addr_in = 32'h200;

    // Reset state
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    idle(2);

    // Single aligned SW, then drain to empty
    push_store(32'h100, 32'hDEADBEEF, 2'd2);
    idle(4);

    // SB to the top byte lane
    push_store(32'h103, 32'h000000AB, 2'd0);
    idle(4);

    // Six stores presented back-to-back against a 4-entry buffer
    for (int i = 0; i < 6; i++) push_store(32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'd2);
    idle(20);

    // Misaligned SH is consumed and sets the sticky error; a later SW still writes
    push_store(32'h101, 32'h0000BEEF, 2'd1);
    idle(3);
    push_store(32'h104, 32'h12345678, 2'd2);
    idle(5);

    // Reset while waiting with three entries queued
    for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + 32'(4 * i), 32'(i + 1), 2'd2, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    idle(8);

    // Forwarding: two full-word stores to the same word, then a partial one
    push_store(32'h200, 32'h11111111, 2'd2);
    push_store(32'h200, 32'h22222222, 2'd2);
    push_store(32'h200, 32'h00000033, 2'd0);
    idle(6);

    // Randomized traffic with occasional resets and illegal stores
    for (int i = 0; i < 600; i++) begin
      rs = 2'($urandom_range(0, 3));
      if (rs == 2'd3 && ($urandom % 4) != 0) rs = 2'd2;
      ra = 32'h300 + 32'($urandom_range(0, 3) * 4);
      if (($urandom % 8) == 0) ra = ra + 32'($urandom_range(0, 3));
      else if (rs == 2'd0) ra = ra + 32'($urandom_range(0, 3));
      else if (rs == 2'd1) ra = ra + 32'(2 * $urandom_range(0, 1));
      ld_addr_in = 32'h300 + 32'($urandom_range(0, 15));
      step(($urandom % 3) != 0, ra, $urandom, rs, ($urandom % 97) == 0);
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
